reg_writeback: RTL

REG_WRITEBACK -- requirements
Module: reg_writeback

---
 rtl/reg_writeback_pkg.sv | 16 +
 rtl/wb_fifo.sv | 60 ++++++
 rtl/reg_writeback.sv | 118 +++++++++++
 3 files changed

// File: rtl/reg_writeback_pkg.sv
// Shared constants and types for the register write-back stage.
// The result-source enum names the winner of each cycle's write-port arbitration.
package reg_writeback_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int WB_DEPTH   = 2;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_ALU,
        SRC_LSU
    } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Small in-order buffer for long-latency (LSU) results.
// The head is readable combinationally, so a pop can be selected in the cycle after the push.
module wb_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push, do_pop;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full     = (count_reg == CNT_W'(DEPTH));
    assign empty    = (count_reg == '0);
    assign count    = count_reg;
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/reg_writeback.sv
// Write-back stage: arbitrates ALU and buffered LSU results onto one registered
// register-bank write port, and tracks registers with outstanding long-latency writes.
module reg_writeback #(
    parameter int XLEN     = reg_writeback_pkg::XLEN,
    parameter int WB_DEPTH = reg_writeback_pkg::WB_DEPTH
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_val,
    input  logic            lsu_valid,
    input  logic [4:0]      lsu_rd,
    input  logic [XLEN-1:0] lsu_val,
    output logic            lsu_ready,
    input  logic            mark_valid,
    input  logic [4:0]      mark_rd,
    output logic            mark_ready,
    input  logic [4:0]      q_rs1,
    input  logic [4:0]      q_rs2,
    output logic            q_rs1_busy,
    output logic            q_rs2_busy,
    output logic            reg_we,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] rd_val,
    output logic            waw_err
);

    import reg_writeback_pkg::*;

    localparam int ENT_W = REG_ADDR_W + XLEN;
    localparam int CNT_W = $clog2(WB_DEPTH + 1);

    logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [ENT_W-1:0]      fifo_head;
    logic [CNT_W-1:0]      fifo_count;
    wb_src_e               sel_src;
    logic [REG_ADDR_W-1:0] sel_rd;
    logic [XLEN-1:0]       sel_val;
    logic [NUM_REGS-1:1]   busy_reg, busy_next;
    logic [NUM_REGS-1:0]   busy_vec;

    // Acceptance depends only on occupancy, never on a same-cycle pop.
    assign lsu_ready = (fifo_count < CNT_W'(WB_DEPTH));
    assign fifo_push = lsu_valid && !fifo_full;

    wb_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (WB_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data ({lsu_rd, lsu_val}),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        sel_src = SRC_NONE;
        sel_rd  = '0;
        sel_val = '0;
        if (alu_valid) begin
            sel_src = SRC_ALU;
            sel_rd  = alu_rd;
            sel_val = alu_val;
        end else if (!fifo_empty) begin
            sel_src = SRC_LSU;
            {sel_rd, sel_val} = fifo_head;
        end
    end

    assign fifo_pop = (sel_src == SRC_LSU);

    // x0 is hard-wired idle, so bit 0 of the lookup vector is constant zero.
    assign busy_vec   = {busy_reg, 1'b0};
    assign mark_ready = !busy_vec[mark_rd];
    assign q_rs1_busy = busy_vec[q_rs1];
    assign q_rs2_busy = busy_vec[q_rs2];

    generate
        for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_busy
            logic set_bit, clr_bit;
            assign set_bit = mark_valid && mark_ready && (mark_rd == REG_ADDR_W'(gi));
            assign clr_bit = (sel_src == SRC_LSU) && (sel_rd == REG_ADDR_W'(gi));
            // A new mark overrides the retiring write to the same register.
            assign busy_next[gi] = set_bit || (busy_reg[gi] && !clr_bit);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            reg_we  <= 1'b0;
            rd      <= '0;
            rd_val  <= '0;
            waw_err <= 1'b0;
        end else begin
            reg_we  <= (sel_src != SRC_NONE) && (sel_rd != '0);
            waw_err <= (sel_src == SRC_ALU) && busy_vec[alu_rd];
            if (sel_src != SRC_NONE) begin
                rd     <= sel_rd;
                rd_val <= sel_val;
            end
        end
    end

endmodule
